// File: rtl/vj_pyramid_pkg.sv
// Shared pyramid definitions: per-level Q8.8 scale factors, the full-resolution
// frame size and the box record passed between the upscaler and its result FIFO.
package vj_pyramid_pkg;

   localparam int LEVEL_W        = 4;
   localparam int PYRAMID_LEVELS = 8;
   localparam int LAPTOP_WIDTH   = 640;
   localparam int LAPTOP_HEIGHT  = 480;

   typedef struct packed {
      logic [15:0] x;
      logic [15:0] y;
      logic [15:0] size;
   } box_t;

   // Each level is downscaled by a further 1.25x, so mapping back multiplies by 1.25^level.
   function automatic logic [15:0] scale_q(input logic [LEVEL_W-1:0] level);
      logic [15:0] q;
      case (level)
         4'd0:    q = 16'd256;
         4'd1:    q = 16'd320;
         4'd2:    q = 16'd400;
         4'd3:    q = 16'd500;
         4'd4:    q = 16'd625;
         4'd5:    q = 16'd781;
         4'd6:    q = 16'd977;
         4'd7:    q = 16'd1221;
         default: q = 16'd0;
      endcase
      return q;
   endfunction

endpackage

// File: rtl/box_fifo.sv
// First-word-fall-through FIFO of box_t records; DEPTH must be a power of two so
// the pointers wrap naturally.
module box_fifo
   import vj_pyramid_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  box_t                     wr_data,
   input  logic                     rd_en,
   output box_t                     rd_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);

   box_t             mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W:0]   cnt_r;

   // Storage, pointers and occupancy; writer guarantees no write into a full FIFO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         cnt_r    <= '0;
      end else begin
         if (wr_en) begin
            mem_r[wr_ptr_r] <= wr_data;
            wr_ptr_r        <= wr_ptr_r + 1'b1;
         end
         if (rd_en) begin
            rd_ptr_r <= rd_ptr_r + 1'b1;
         end
         case ({wr_en, rd_en})
            2'b10:   cnt_r <= cnt_r + 1'b1;
            2'b01:   cnt_r <= cnt_r - 1'b1;
            default: cnt_r <= cnt_r;
         endcase
      end
   end

   assign rd_data = mem_r[rd_ptr_r];
   assign count   = cnt_r;

endmodule

// File: rtl/face_box_upscaler.sv
// Maps detector hits (level, x, y) back to full-resolution boxes through a
// two-stage scale/round pipeline into a FWFT result FIFO. Optional BOX_CLIP_EN.
module face_box_upscaler
   import vj_pyramid_pkg::*;
#(
   parameter int FIFO_DEPTH  = 4,
   parameter int WINDOW_SIZE = 24,
   parameter int SCALE_FRAC  = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               frame_start,
   input  logic               det_valid,
   output logic               det_ready,
   input  logic [LEVEL_W-1:0] det_level,
   input  logic [15:0]        det_x,
   input  logic [15:0]        det_y,
   output logic               box_valid,
   input  logic               box_ready,
   output logic [15:0]        box_x,
   output logic [15:0]        box_y,
   output logic [15:0]        box_size,
   output logic [7:0]         box_count,
   output logic               err_level
);

   localparam int          CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [31:0] RND   = 32'd1 << (SCALE_FRAC - 1);

   logic             ready_en_r;
   logic             s1_valid_r;
   logic [15:0]      s1_x_r;
   logic [15:0]      s1_y_r;
   logic [15:0]      s1_scale_r;
   logic [7:0]       box_count_r;
   logic             err_level_r;
   logic             acc_s;
   logic             lvl_ok_s;
   logic             pop_s;
   logic [CNT_W-1:0] fifo_cnt_s;
   logic [CNT_W:0]   occ_s;
   box_t             res_s;
   box_t             head_s;

   function automatic logic [15:0] scale_round(input logic [15:0] v, input logic [15:0] s);
      logic [31:0] sum;
      sum = (32'(v) * 32'(s)) + RND;
      return sum[SCALE_FRAC+15:SCALE_FRAC];
   endfunction

   assign acc_s     = det_valid && det_ready;
   assign lvl_ok_s  = ({1'b0, det_level} < (LEVEL_W+1)'(PYRAMID_LEVELS));
   assign pop_s     = box_valid && box_ready;
   assign occ_s     = {1'b0, fifo_cnt_s} + {{CNT_W{1'b0}}, s1_valid_r};
   // Stage-1 occupancy counts toward capacity so an accepted hit always has a FIFO slot.
   assign det_ready = ready_en_r && (occ_s < (CNT_W+1)'(FIFO_DEPTH));

   // Stage 1: capture coordinates and the level's scale factor; illegal levels are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_r <= 1'b0;
         s1_x_r     <= 16'd0;
         s1_y_r     <= 16'd0;
         s1_scale_r <= 16'd0;
      end else begin
         s1_valid_r <= acc_s && lvl_ok_s;
         if (acc_s && lvl_ok_s) begin
            s1_x_r     <= det_x;
            s1_y_r     <= det_y;
            s1_scale_r <= scale_q(det_level);
         end
      end
   end

   // Stage 2: rounded scaling, optionally clipped to the frame, feeding the FIFO write.
   always_comb begin
      res_s      = '0;
      res_s.x    = scale_round(s1_x_r, s1_scale_r);
      res_s.y    = scale_round(s1_y_r, s1_scale_r);
      res_s.size = scale_round(16'(WINDOW_SIZE), s1_scale_r);
`ifdef BOX_CLIP_EN
      if (res_s.size > 16'(LAPTOP_HEIGHT)) begin
         res_s.size = 16'(LAPTOP_HEIGHT);
      end else begin
         res_s.size = res_s.size;
      end
      if (res_s.x > (16'(LAPTOP_WIDTH) - res_s.size)) begin
         res_s.x = 16'(LAPTOP_WIDTH) - res_s.size;
      end else begin
         res_s.x = res_s.x;
      end
      if (res_s.y > (16'(LAPTOP_HEIGHT) - res_s.size)) begin
         res_s.y = 16'(LAPTOP_HEIGHT) - res_s.size;
      end else begin
         res_s.y = res_s.y;
      end
`endif
   end

   box_fifo #(
      .DEPTH   (FIFO_DEPTH)
   ) u_box_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (s1_valid_r),
      .wr_data (res_s),
      .rd_en   (pop_s),
      .rd_data (head_s),
      .count   (fifo_cnt_s)
   );

   // Ready enable, per-frame pop counter and sticky illegal-level flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_en_r  <= 1'b0;
         box_count_r <= 8'd0;
         err_level_r <= 1'b0;
      end else begin
         ready_en_r <= 1'b1;
         if (frame_start) begin
            box_count_r <= pop_s ? 8'd1 : 8'd0;
         end else if (pop_s && (box_count_r != 8'd255)) begin
            box_count_r <= box_count_r + 8'd1;
         end else begin
            box_count_r <= box_count_r;
         end
         if (acc_s && !lvl_ok_s) begin
            err_level_r <= 1'b1;
         end else if (frame_start) begin
            err_level_r <= 1'b0;
         end else begin
            err_level_r <= err_level_r;
         end
      end
   end

   assign box_valid = (fifo_cnt_s != '0);
   assign box_x     = head_s.x;
   assign box_y     = head_s.y;
   assign box_size  = head_s.size;
   assign box_count = box_count_r;
   assign err_level = err_level_r;

endmodule

// File: tb/tb_face_box_upscaler.sv
// Directed scoreboard bench for face_box_upscaler; clipping checks follow BOX_CLIP_EN.
module tb_face_box_upscaler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        frame_start;
   logic        det_valid;
   logic        det_ready;
   logic [3:0]  det_level;
   logic [15:0] det_x;
   logic [15:0] det_y;
   logic        box_valid;
   logic        box_ready;
   logic [15:0] box_x;
   logic [15:0] box_y;
   logic [15:0] box_size;
   logic [7:0]  box_count;
   logic        err_level;

   int          tests = 0;
   int          fails = 0;
   int          accepted = 0;
   logic [47:0] sb [$];

   always #5 clk = ~clk;

   face_box_upscaler dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_start (frame_start),
      .det_valid   (det_valid),
      .det_ready   (det_ready),
      .det_level   (det_level),
      .det_x       (det_x),
      .det_y       (det_y),
      .box_valid   (box_valid),
      .box_ready   (box_ready),
      .box_x       (box_x),
      .box_y       (box_y),
      .box_size    (box_size),
      .box_count   (box_count),
      .err_level   (err_level)
   );

   function automatic int tb_scale(input int lvl);
      case (lvl)
         0:       return 256;
         1:       return 320;
         2:       return 400;
         3:       return 500;
         4:       return 625;
         5:       return 781;
         6:       return 977;
         7:       return 1221;
         default: return 0;
      endcase
   endfunction

   function automatic logic [47:0] exp_box(input int lvl, input int x, input int y);
      longint s, bx, by, bs;
      s  = longint'(tb_scale(lvl));
      bx = (longint'(x) * s + 128) / 256;
      by = (longint'(y) * s + 128) / 256;
      bs = (24 * s + 128) / 256;
`ifdef BOX_CLIP_EN
      if (bs > 480) bs = 480;
      if (bx > 640 - bs) bx = 640 - bs;
      if (by > 480 - bs) by = 480 - bs;
`endif
      return {bx[15:0], by[15:0], bs[15:0]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // One clock: score handshakes seen just before the edge, then return #1 after it.
   task automatic tick();
      logic [47:0] e;
      #1;
      if (det_valid && det_ready) begin
         accepted++;
         if (det_level < 4'd8) sb.push_back(exp_box(int'(det_level), int'(det_x), int'(det_y)));
      end
      if (box_valid && box_ready) begin
         tests++;
         assert (sb.size() != 0) else begin
            fails++;
            $error("FAIL unexpected_box: observed x=%0d y=%0d size=%0d expected no box", box_x, box_y, box_size);
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("box_x", 32'(box_x), 32'(e[47:32]));
            chk("box_y", 32'(box_y), 32'(e[31:16]));
            chk("box_size", 32'(box_size), 32'(e[15:0]));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic hit(input logic [3:0] l, input logic [15:0] x, input logic [15:0] y);
      det_valid = 1'b1;
      det_level = l;
      det_x     = x;
      det_y     = y;
   endtask

   initial begin
      logic [15:0] held_x;
      int          budget;
      rst_n = 1'b0; frame_start = 1'b0; det_valid = 1'b0; det_level = 4'd0;
      det_x = 16'd0; det_y = 16'd0; box_ready = 1'b0;
      #2;
      chk("rst_det_ready", 32'(det_ready), 32'd0);
      chk("rst_box_valid", 32'(box_valid), 32'd0);
      chk("rst_box_x", 32'(box_x), 32'd0);
      chk("rst_box_count", 32'(box_count), 32'd0);
      chk("rst_err_level", 32'(err_level), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick();
      chk("post_rst_det_ready", 32'(det_ready), 32'd1);

      // Level 0 passthrough and two-cycle latency
      hit(4'd0, 16'd10, 16'd20);
      tick();
      det_valid = 1'b0;
      chk("lat_edge_n", 32'(box_valid), 32'd0);
      tick();
      chk("lat_edge_n1", 32'(box_valid), 32'd1);
      chk("l0_x", 32'(box_x), 32'd10);
      chk("l0_y", 32'(box_y), 32'd20);
      chk("l0_size", 32'(box_size), 32'd24);
      box_ready = 1'b1;
      tick();
      chk("count_after_1", 32'(box_count), 32'd1);

      // Level 1 scaling with round-half-up
      hit(4'd1, 16'd8, 16'd16);
      tick();
      hit(4'd1, 16'd7, 16'd3);
      tick();
      det_valid = 1'b0;
      chk("l1_x", 32'(box_x), 32'd10);
      chk("l1_size", 32'(box_size), 32'd30);
      for (int i = 0; i < 4; i++) tick();
      chk("l1_drained", 32'(sb.size()), 32'd0);

      // Back-pressure: six offered hits, four fit
      box_ready = 1'b0;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      chk("fs_count_clear", 32'(box_count), 32'd0);
      accepted = 0;
      for (int i = 0; i < 6; i++) begin
         hit(4'd2, 16'(i * 10 + 3), 16'(i * 5 + 1));
         tick();
         if (i == 3) chk("ready_drop_4th", 32'(det_ready), 32'd0);
      end
      det_valid = 1'b0;
      tick();
      chk("bp_accepted", 32'(accepted), 32'd4);
      held_x = box_x;
      tick();
      chk("hold_stable", 32'(box_x), 32'(held_x));
      chk("hold_valid", 32'(box_valid), 32'd1);
      box_ready = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      chk("bp_count", 32'(box_count), 32'd4);
      chk("bp_drained", 32'(sb.size()), 32'd0);

      // Illegal level and frame_start interactions
      hit(4'd15, 16'd1, 16'd1);
      tick();
      det_valid = 1'b0;
      chk("err_set", 32'(err_level), 32'd1);
      tick(); tick();
      chk("err_no_box", 32'(box_valid), 32'd0);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      chk("err_cleared", 32'(err_level), 32'd0);
      chk("err_fs_count", 32'(box_count), 32'd0);
      frame_start = 1'b1;
      hit(4'd9, 16'd0, 16'd0);
      tick();
      frame_start = 1'b0;
      det_valid = 1'b0;
      chk("fs_with_illegal", 32'(err_level), 32'd1);
      box_ready = 1'b0;
      hit(4'd3, 16'd40, 16'd50);
      tick();
      det_valid = 1'b0;
      tick();
      box_ready = 1'b1;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      chk("fs_with_pop", 32'(box_count), 32'd1);

      // Saturation of box_count
      accepted = 0;
      budget = 0;
      while (accepted < 260 && budget < 2000) begin
         hit(4'd0, 16'(accepted), 16'd7);
         tick();
         budget++;
      end
      det_valid = 1'b0;
      chk("sat_budget", 32'(accepted >= 260), 32'd1);
      for (int i = 0; i < 4; i++) tick();
      chk("sat_count", 32'(box_count), 32'd255);

      // Asynchronous reset with three boxes queued
      box_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         hit(4'd1, 16'(i + 1), 16'(i + 2));
         tick();
      end
      det_valid = 1'b0;
      tick(); tick();
      chk("pre_rst_valid", 32'(box_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(box_valid), 32'd0);
      chk("async_rst_ready", 32'(det_ready), 32'd0);
      sb.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      box_ready = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      chk("post_rst_empty", 32'(box_valid), 32'd0);

`ifdef BOX_CLIP_EN
      box_ready = 1'b0;
      hit(4'd7, 16'd600, 16'd10);
      tick();
      det_valid = 1'b0;
      tick();
      chk("clip_right_edge", 32'(box_x) + 32'(box_size), 32'd640);
      box_ready = 1'b1;
      tick(); tick();
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
